// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : SPI mode-0 byte receiver clocked entirely by clk; SCK/SS/MOSI
//               are oversampled through synchroniser chains. Optional MISO
//               echo of the previously received byte via SPI_SLAVE_MISO_ECHO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hw_spi_clk,
    input  logic       hw_spi_ss,
    input  logic       hw_spi_mosi,
    output logic       hw_spi_miso,
    output logic       spi_active,
    output logic [7:0] byte_out,
    output logic       byte_ready
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   ss_hist_q, ss_hist_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [7:0]             byte_out_q, byte_out_d;
    logic                   byte_ready_q, byte_ready_d;

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_rise;
    logic ss_assert;
    logic byte_done;

    // ------------------------------------------------------------------
    // Synchroniser chains and edge-detect history
    // ------------------------------------------------------------------
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], hw_spi_clk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], hw_spi_ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], hw_spi_mosi};
        sck_hist_d  = sck_sync_q[SYNC_STAGES-1];
        ss_hist_d   = ss_sync_q[SYNC_STAGES-1];
    end

    // SS resets to idle-high and SCK to low so release never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            ss_hist_q   <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_hist_q  <= sck_hist_d;
            ss_hist_q   <= ss_hist_d;
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_hist_q;
    assign ss_assert = ~ss_s & ss_hist_q;
    assign byte_done = ~ss_s & ~ss_assert & sck_rise & (bit_cnt_q == 3'd7);

    // ------------------------------------------------------------------
    // Receive datapath
    // ------------------------------------------------------------------
    // An SCK edge coinciding with the SS assertion cycle is ambiguous and is
    // treated like the idle state; real mode-0 masters never do this.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_ready_d = 1'b0;
        if (ss_s || ss_assert) begin
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
        end else if (sck_rise) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_out_d   = {shift_q, mosi_s};
                byte_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_out_q   <= 8'h00;
            byte_ready_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign spi_active = ~ss_s;
    assign byte_out   = byte_out_q;
    assign byte_ready = byte_ready_q;

    // ------------------------------------------------------------------
    // MISO
    // ------------------------------------------------------------------
`ifdef SPI_SLAVE_MISO_ECHO_EN
    logic [7:0] tx_q, tx_d;
    logic       sck_fall;

    assign sck_fall = ~sck_s & sck_hist_q;

    // The falling edge right after bit 8 (counter back at 0) must not shift,
    // otherwise the freshly loaded MSB would be lost before it is sampled.
    always_comb begin
        tx_d = tx_q;
        if (byte_done) begin
            tx_d = byte_out_d;
        end else if (ss_assert) begin
            tx_d = byte_out_q;
        end else if (sck_fall && !ss_s && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= 8'h00;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign hw_spi_miso = tx_q[7];
`else
    assign hw_spi_miso = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// Directed bench for spi_slave_sync: SPI master model at clk/8 with a
// byte_ready monitor collecting every received byte.
module tb_spi_slave_sync;

    logic       clk;
    logic       rst;
    logic       hw_spi_clk;
    logic       hw_spi_ss;
    logic       hw_spi_mosi;
    logic       hw_spi_miso;
    logic       spi_active;
    logic [7:0] byte_out;
    logic       byte_ready;

    int         checks;
    int         errors;
    logic [7:0] rx_q[$];
    logic       track_active;
    logic       active_dropped;

    spi_slave_sync #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .hw_spi_clk (hw_spi_clk),
        .hw_spi_ss  (hw_spi_ss),
        .hw_spi_mosi(hw_spi_mosi),
        .hw_spi_miso(hw_spi_miso),
        .spi_active (spi_active),
        .byte_out   (byte_out),
        .byte_ready (byte_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_ready) rx_q.push_back(byte_out);
        if (track_active && !spi_active) active_dropped = 1'b1;
    end

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            hw_spi_mosi = b[i];
            repeat (4) @(negedge clk);
            miso_b[i] = hw_spi_miso;
            hw_spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            hw_spi_clk = 1'b0;
        end
    endtask

    task automatic ss_low();
        hw_spi_ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (8) @(negedge clk);
        hw_spi_ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out got %h exp 00", byte_out); end
        checks++;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b exp 0", byte_ready); end
        checks++;
        if (spi_active !== 1'b0) begin errors++; $display("FAIL reset_spi_active got %b exp 0", spi_active); end
        checks++;
        if (hw_spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", hw_spi_miso); end
        checks++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] m;
        rx_q.delete();
        ss_low();
        if (spi_active !== 1'b1) begin errors++; $display("FAIL single_active_on got %b exp 1", spi_active); end
        checks++;
        active_dropped = 1'b0;
        track_active   = 1'b1;
        send_bits(8'hA5, 8, m);
        repeat (8) @(negedge clk);
        track_active = 1'b0;
        if (rx_q.size() !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", rx_q.size()); end
        checks++;
        if (byte_out !== 8'hA5) begin errors++; $display("FAIL single_byte got %h exp a5", byte_out); end
        checks++;
        if (active_dropped !== 1'b0) begin errors++; $display("FAIL single_active_held got drop=%b exp 0", active_dropped); end
        checks++;
        ss_high();
        if (spi_active !== 1'b0) begin errors++; $display("FAIL single_active_off got %b exp 0", spi_active); end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] m;
        logic [7:0] exp_b[3];
        logic [7:0] got;
        exp_b[0] = 8'h0C; exp_b[1] = 8'h12; exp_b[2] = 8'h34;
        rx_q.delete();
        ss_low();
        for (int k = 0; k < 3; k++) send_bits(exp_b[k], 8, m);
        ss_high();
        if (rx_q.size() !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", rx_q.size()); end
        checks++;
        for (int k = 0; k < 3; k++) begin
            got = (rx_q.size() > k) ? rx_q[k] : 8'hEE;
            if (got !== exp_b[k]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", k, got, exp_b[k]); end
            checks++;
        end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        rx_q.delete();
        ss_low();
        send_bits(8'hF0, 5, m);
        ss_high();
        if (rx_q.size() !== 0) begin errors++; $display("FAIL abort_no_pulse got %0d exp 0", rx_q.size()); end
        checks++;
        if (byte_out !== 8'h34) begin errors++; $display("FAIL abort_hold got %h exp 34", byte_out); end
        checks++;
        ss_low();
        send_bits(8'h3C, 8, m);
        ss_high();
        if (rx_q.size() !== 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", rx_q.size()); end
        checks++;
        if (byte_out !== 8'h3C) begin errors++; $display("FAIL abort_byte got %h exp 3c", byte_out); end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        rx_q.delete();
        ss_low();
        send_bits(8'hFF, 4, m);
        rst = 1'b1;
        #1;
        if (byte_out !== 8'h00) begin errors++; $display("FAIL rstmid_byte_out got %h exp 00", byte_out); end
        checks++;
        if (spi_active !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b exp 0", spi_active); end
        checks++;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", byte_ready); end
        checks++;
        hw_spi_ss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rx_q.delete();
        ss_low();
        send_bits(8'h81, 8, m);
        ss_high();
        if (rx_q.size() !== 1) begin errors++; $display("FAIL rstmid_pulses got %0d exp 1", rx_q.size()); end
        checks++;
        if (byte_out !== 8'h81) begin errors++; $display("FAIL rstmid_byte got %h exp 81", byte_out); end
        checks++;
    endtask

    task automatic test_miso();
        logic [7:0] m1, m2, exp2;
`ifdef SPI_SLAVE_MISO_ECHO_EN
        exp2 = 8'h5A;
`else
        exp2 = 8'h00;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rx_q.delete();
        ss_low();
        send_bits(8'h5A, 8, m1);
        send_bits(8'hC3, 8, m2);
        ss_high();
        if (m1 !== 8'h00) begin errors++; $display("FAIL miso_byte1 got %h exp 00", m1); end
        checks++;
        if (m2 !== exp2) begin errors++; $display("FAIL miso_byte2 got %h exp %h", m2, exp2); end
        checks++;
        if (rx_q.size() !== 2) begin errors++; $display("FAIL miso_pulses got %0d exp 2", rx_q.size()); end
        checks++;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        hw_spi_clk     = 1'b0;
        hw_spi_ss      = 1'b1;
        hw_spi_mosi    = 1'b0;
        track_active   = 1'b0;
        active_dropped = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_miso();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops per SPI input (legal 2..4).
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port hw_spi_clk, input, 1, SPI SCK from the master, asynchronous to clk.
REQ-005 The block SHALL have port hw_spi_ss, input, 1, SPI slave select, active low, asynchronous to clk.
REQ-006 The block SHALL have port hw_spi_mosi, input, 1, SPI data from the master, asynchronous to clk.
REQ-007 The block SHALL have port hw_spi_miso, output, 1, SPI data to the master.
REQ-008 The block SHALL have port spi_active, output, 1, high while the synchronised slave select is asserted.
REQ-009 The block SHALL have port byte_out, output, 8, last complete received byte, MSB first on the wire.
REQ-010 The block SHALL have port byte_ready, output, 1, single-cycle pulse marking a new byte_out.

Function
REQ-011 The block SHALL operate in SPI mode 0: MOSI sampled on SCK rising edge, MISO changed on SCK falling edge.
REQ-012 The block SHALL pass each of SCK, SS and MOSI through SYNC_STAGES flops plus one history flop for SCK and SS edge detection.
REQ-013 The block SHALL support SCK frequencies up to clk/8; faster SCK is outside the requirements.
REQ-014 spi_active SHALL equal the inverse of the final SS synchroniser stage.
REQ-015 The 3-bit bit counter and partial shift register SHALL clear on every clk cycle where synchronised SS is high.
REQ-016 On a detected SCK rising edge while spi_active, the block SHALL shift synchronised MOSI into the shift register LSB and increment the bit counter, wrapping 7 -> 0.
REQ-017 On the rising edge completing bit 8 (counter 7), byte_out SHALL load {shift[6:0], mosi} and byte_ready SHALL be high for exactly one clk cycle, in the clk cycle after the edge was detected.
REQ-018 Latency: byte_ready SHALL assert no later than SYNC_STAGES + 2 clk cycles after the 8th SCK rising edge.
REQ-019 byte_out SHALL hold its value until the next completed byte or reset.
REQ-020 SS deasserting mid-byte SHALL discard the partial byte with no byte_ready; the next byte starts at bit 0.
REQ-021 If an SCK rising edge and SS deassertion are detected in the same clk cycle, SS deassertion SHALL take priority and the edge is ignored.
REQ-022 SCK edges while synchronised SS is high SHALL have no effect.
REQ-023 Back-to-back bytes without SS deassertion SHALL each produce their own byte_ready pulse.

Reset
REQ-024 rst SHALL asynchronously force byte_out = 8'h00, byte_ready = 0, spi_active = 0, hw_spi_miso = 0, bit counter = 0, shift registers = 0.
REQ-025 On reset, SS synchroniser and history flops SHALL load 1 (idle) and SCK flops SHALL load 0, so no spurious edge is seen on release.
REQ-026 rst asserted mid-byte SHALL discard the partial byte; after release, reception restarts only on the next SS assertion.

Configuration
REQ-027 Macro SPI_SLAVE_MISO_ECHO_EN SHALL control MISO behaviour.
REQ-028 With SPI_SLAVE_MISO_ECHO_EN defined, a TX register SHALL load byte_out on each byte completion and on SS assertion; its MSB drives hw_spi_miso, and it shifts left on each detected SCK falling edge while spi_active.
REQ-029 With SPI_SLAVE_MISO_ECHO_EN defined, the master SHALL read during byte N the byte received as byte N-1, and 8'h00 for the first byte after reset.
REQ-030 Without SPI_SLAVE_MISO_ECHO_EN, hw_spi_miso SHALL be constant 0 and no TX register SHALL exist.

Verification
REQ-031 Reset, then SS low, send 8'hA5 at clk/8 -> one byte_ready pulse, byte_out = 8'hA5, spi_active high throughout.
REQ-032 Send 8'h0C, 8'h12, 8'h34 in one SS frame -> three pulses carrying 8'h0C, 8'h12, 8'h34 in order.
REQ-033 Send 5 bits, raise SS, lower SS, send 8'h3C -> no pulse for the partial byte, one pulse with byte_out = 8'h3C.
REQ-034 Assert rst after 4 bits of 8'hFF, release, send 8'h81 in a new frame -> byte_out = 8'h00 during reset, then one pulse with 8'h81.
REQ-035 With echo enabled, send 8'h5A then 8'hC3 in one frame -> MISO reads 8'h00 during byte 1 and 8'h5A during byte 2; with echo disabled, MISO is constantly 0.
